// File: rtl/nanorv32_csr_pkg.sv
// Shared CSR address map and counter/inhibit bit indices for the Nanorv32 counter bank.
// Latency: n/a (constants and a constant function only).
// Backpressure: n/a.
package nanorv32_csr_pkg;

  typedef logic [11:0] csr_addr_t;

  // Counter CSR bases; counter N lives at base + N.
  localparam csr_addr_t CSR_MCNT_LO       = 12'hB00;
  localparam csr_addr_t CSR_MCNT_HI       = 12'hB80;
  localparam csr_addr_t CSR_UCNT_LO       = 12'hC00;
  localparam csr_addr_t CSR_UCNT_HI       = 12'hC80;
  // mcountinhibit sits at offset 0 of the event-select page.
  localparam csr_addr_t CSR_MCOUNTINHIBIT = 12'h320;
  localparam csr_addr_t CSR_OVF_FLAGS     = 12'h7C0;
  localparam csr_addr_t CSR_OVF_MASK      = 12'h7C1;

  // Counter index == inhibit bit == overflow flag bit.
  localparam int INH_CY   = 0;
  localparam int IDX_TIME = 1;
  localparam int INH_IR   = 2;
  localparam int INH_HPM0 = 3;

  // Bit set of counter indices that have real storage (time is only an alias).
  function automatic logic [31:0] impl_mask(input int num_hpm);
    logic [31:0] m;
    m         = 32'h0;
    m[INH_CY] = 1'b1;
    m[INH_IR] = 1'b1;
    for (int i = 0; i < num_hpm; i++) m[INH_HPM0 + i] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/nanorv32_csr_counter.sv
// One CNT_WIDTH counter with independent 32-bit low/high write ports and a wrap pulse.
// Latency: value updates one clock after inc/wr; wrap is combinational in the wrapping cycle.
// Backpressure: none; a write to either half discards that cycle's increment entirely.
module nanorv32_csr_counter #(
  parameter int CNT_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  input  logic                 wr_lo,
  input  logic                 wr_hi,
  input  logic [31:0]          wdata,
  output logic [CNT_WIDTH-1:0] value,
  output logic                 wrap
);

  logic        wr_hi_eff;
  logic [63:0] cur_ext;
  logic [63:0] nxt_ext;

  // A 32-bit counter has no high half, so high writes are simply dropped.
  assign wr_hi_eff = (CNT_WIDTH > 32) ? wr_hi : 1'b0;

  // Only a genuine increment out of all-ones counts as a wrap; write-induced zeros do not.
  assign wrap = inc & ~wr_lo & ~wr_hi_eff & (&value);

  // Next value: the written half wins and the other half holds, so no carry leaks in.
  always_comb begin
    cur_ext = 64'(value);
    nxt_ext = cur_ext;
    if (wr_lo)
      nxt_ext[31:0] = wdata;
    else if (wr_hi_eff)
      nxt_ext[63:32] = wdata;
    else if (inc)
      nxt_ext = cur_ext + 64'd1;
  end

  // Counter state; bits above CNT_WIDTH are dropped, which also gives the wrap to 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      value <= '0;
    else
      value <= nxt_ext[CNT_WIDTH-1:0];
  end

endmodule

// File: rtl/nanorv32_csr_counters.sv
// Nanorv32 cycle/instret/HPM counter bank with mcountinhibit, event selects and optional
// overflow IRQ (define NANORV32_CSR_OVF_IRQ_EN). Latency: reads combinational, writes at clk.
// Backpressure: none; one CSR write per cycle, force_stall_reset freezes counting only.
module nanorv32_csr_counters
  import nanorv32_csr_pkg::*;
#(
  parameter int NUM_HPM    = 4,
  parameter int CNT_WIDTH  = 64,
  parameter int NUM_EVENTS = 8,
  parameter int EVT_W      = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [11:0]           core_csr_addr,
  input  logic [31:0]           core_csr_wdata,
  input  logic                  core_csr_write,
  output logic [31:0]           csr_core_rdata,
  output logic                  csr_core_hit,
  input  logic                  force_stall_reset,
  input  logic                  stall_exe,
  input  logic [NUM_EVENTS-1:0] hpm_events,
  output logic                  csr_ovf_irq
);

  localparam int          NCNT        = 3 + NUM_HPM;
  localparam int          HPM_N       = (NUM_HPM > 0) ? NUM_HPM : 1;
  localparam logic [31:0] IMPL_MASK   = impl_mask(NUM_HPM);
  localparam logic [31:0] SHADOW_MASK = IMPL_MASK | (32'h1 << IDX_TIME);

  logic [4:0]       off;
  logic             in_mlo, in_mhi, in_ulo, in_uhi, in_evt;
  logic             count_ok;
  logic [31:0]      inhibit;
  logic [EVT_W-1:0] evt_sel [HPM_N];
  logic [HPM_N-1:0] hpm_fire;
  logic [63:0]      cnt_ext [NCNT];
  logic [NCNT-1:0]  wrap_vec;
  logic [63:0]      rd_cnt;
  logic [EVT_W-1:0] rd_evt;

  // Every region is a 32-entry page; the low 5 address bits pick the counter index.
  assign off      = core_csr_addr[4:0];
  assign in_mlo   = core_csr_addr[11:5] == CSR_MCNT_LO[11:5];
  assign in_mhi   = core_csr_addr[11:5] == CSR_MCNT_HI[11:5];
  assign in_ulo   = core_csr_addr[11:5] == CSR_UCNT_LO[11:5];
  assign in_uhi   = core_csr_addr[11:5] == CSR_UCNT_HI[11:5];
  assign in_evt   = core_csr_addr[11:5] == CSR_MCOUNTINHIBIT[11:5];
  assign count_ok = ~force_stall_reset;

  // Event match per HPM counter; id 0 and ids beyond NUM_EVENTS never match.
  always_comb begin
    hpm_fire = '0;
    for (int j = 0; j < NUM_HPM; j++)
      for (int k = 0; k < NUM_EVENTS; k++)
        if (32'(evt_sel[j]) == 32'(k + 1) && hpm_events[k]) hpm_fire[j] = 1'b1;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NCNT; gi++) begin : g_cnt
      if (gi == IDX_TIME) begin : g_time_alias
        assign cnt_ext[gi]  = cnt_ext[INH_CY];
        assign wrap_vec[gi] = 1'b0;
      end else begin : g_counter
        logic                 inc, wr_lo, wr_hi;
        logic [CNT_WIDTH-1:0] value;
        assign wr_lo = core_csr_write & in_mlo & (off == 5'(gi));
        assign wr_hi = core_csr_write & in_mhi & (off == 5'(gi));
        if (gi == INH_CY) begin : g_cy
          assign inc = count_ok & ~inhibit[gi];
        end else if (gi == INH_IR) begin : g_ir
          assign inc = count_ok & ~inhibit[gi] & ~stall_exe;
        end else begin : g_hpm
          assign inc = count_ok & ~inhibit[gi] & hpm_fire[gi - INH_HPM0];
        end
        nanorv32_csr_counter #(.CNT_WIDTH(CNT_WIDTH)) u_counter (
          .clk   (clk),
          .rst   (rst),
          .inc   (inc),
          .wr_lo (wr_lo),
          .wr_hi (wr_hi),
          .wdata (core_csr_wdata),
          .value (value),
          .wrap  (wrap_vec[gi])
        );
        assign cnt_ext[gi] = 64'(value);
      end
    end
  endgenerate

  // mcountinhibit and event selects; writes are honoured even while counting is frozen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inhibit <= '0;
      for (int j = 0; j < HPM_N; j++) evt_sel[j] <= '0;
    end else if (core_csr_write) begin
      if (core_csr_addr == CSR_MCOUNTINHIBIT)
        inhibit <= core_csr_wdata & IMPL_MASK;
      for (int j = 0; j < NUM_HPM; j++)
        if (in_evt && off == 5'(j + INH_HPM0)) evt_sel[j] <= core_csr_wdata[EVT_W-1:0];
    end
  end

`ifdef NANORV32_CSR_OVF_IRQ_EN
  logic [31:0] ovf_flags, ovf_mask, flags_nxt, mask_nxt;

  // Sticky flags with W1C; OR-ing the wrap set last makes set win over clear.
  always_comb begin
    flags_nxt = ovf_flags;
    mask_nxt  = ovf_mask;
    if (core_csr_write && core_csr_addr == CSR_OVF_FLAGS)
      flags_nxt = flags_nxt & ~core_csr_wdata;
    flags_nxt = flags_nxt | 32'(wrap_vec);
    if (core_csr_write && core_csr_addr == CSR_OVF_MASK)
      mask_nxt = core_csr_wdata & IMPL_MASK;
  end

  // IRQ is registered from next-state values so it rises on the same edge as the flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_flags   <= '0;
      ovf_mask    <= '0;
      csr_ovf_irq <= 1'b0;
    end else begin
      ovf_flags   <= flags_nxt;
      ovf_mask    <= mask_nxt;
      csr_ovf_irq <= |(flags_nxt & mask_nxt);
    end
  end
`else
  logic unused_wrap;
  assign unused_wrap = ^wrap_vec;
  assign csr_ovf_irq = 1'b0;
`endif

  // Select the counter and event register addressed by the low offset bits.
  always_comb begin
    rd_cnt = '0;
    rd_evt = '0;
    for (int i = 0; i < NCNT; i++)
      if (off == 5'(i)) rd_cnt = cnt_ext[i];
    for (int j = 0; j < NUM_HPM; j++)
      if (off == 5'(j + INH_HPM0)) rd_evt = evt_sel[j];
  end

  // Read decode: registered values only, unmapped addresses give hit=0 and data 0.
  always_comb begin
    csr_core_rdata = '0;
    csr_core_hit   = 1'b0;
    if (in_mlo && IMPL_MASK[off]) begin
      csr_core_hit   = 1'b1;
      csr_core_rdata = rd_cnt[31:0];
    end else if (in_mhi && IMPL_MASK[off]) begin
      csr_core_hit   = 1'b1;
      csr_core_rdata = rd_cnt[63:32];
    end else if (in_ulo && SHADOW_MASK[off]) begin
      csr_core_hit   = 1'b1;
      csr_core_rdata = rd_cnt[31:0];
    end else if (in_uhi && SHADOW_MASK[off]) begin
      csr_core_hit   = 1'b1;
      csr_core_rdata = rd_cnt[63:32];
    end else if (core_csr_addr == CSR_MCOUNTINHIBIT) begin
      csr_core_hit   = 1'b1;
      csr_core_rdata = inhibit;
    end else if (in_evt && off >= 5'(INH_HPM0) && IMPL_MASK[off]) begin
      csr_core_hit   = 1'b1;
      csr_core_rdata = 32'(rd_evt);
`ifdef NANORV32_CSR_OVF_IRQ_EN
    end else if (core_csr_addr == CSR_OVF_FLAGS) begin
      csr_core_hit   = 1'b1;
      csr_core_rdata = ovf_flags;
    end else if (core_csr_addr == CSR_OVF_MASK) begin
      csr_core_hit   = 1'b1;
      csr_core_rdata = ovf_mask;
`endif
    end
  end

endmodule

// File: tb/tb_nanorv32_csr_counters.sv
// Self-checking bench for nanorv32_csr_counters: expected reads are queued, then drained
// against the DUT while counting is frozen. Covers reset, counting, events, wrap, inhibit, IRQ.
module tb_nanorv32_csr_counters;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] core_csr_addr;
  logic [31:0] core_csr_wdata;
  logic        core_csr_write;
  logic [31:0] csr_core_rdata;
  logic        csr_core_hit;
  logic        force_stall_reset;
  logic        stall_exe;
  logic [7:0]  hpm_events;
  logic        csr_ovf_irq;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [11:0] addr;
    logic [31:0] data;
    logic        hit;
  } rd_exp_t;

  rd_exp_t    exp_q[$];
  logic [7:0] ev_pat [5] = '{8'h02, 8'h01, 8'h02, 8'h01, 8'h02};

  always #5 clk = ~clk;

  nanorv32_csr_counters #(
    .NUM_HPM(4), .CNT_WIDTH(64), .NUM_EVENTS(8), .EVT_W(5)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .core_csr_addr     (core_csr_addr),
    .core_csr_wdata    (core_csr_wdata),
    .core_csr_write    (core_csr_write),
    .csr_core_rdata    (csr_core_rdata),
    .csr_core_hit      (csr_core_hit),
    .force_stall_reset (force_stall_reset),
    .stall_exe         (stall_exe),
    .hpm_events        (hpm_events),
    .csr_ovf_irq       (csr_ovf_irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
    core_csr_addr  = a;
    core_csr_wdata = d;
    core_csr_write = 1'b1;
    tick();
    core_csr_write = 1'b0;
  endtask

  task automatic expect_rd(input logic [11:0] a, input logic [31:0] d, input logic h);
    rd_exp_t e;
    e.addr = a;
    e.data = d;
    e.hit  = h;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    rd_exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge clk);
      core_csr_addr = e.addr;
      #1;
      check($sformatf("rd_%03h", e.addr), csr_core_rdata, e.data);
      check($sformatf("hit_%03h", e.addr), 32'(csr_core_hit), 32'(e.hit));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    core_csr_addr = '0;
    core_csr_wdata = '0;
    core_csr_write = 1'b0;
    force_stall_reset = 1'b0;
    stall_exe = 1'b0;
    hpm_events = '0;
    #2;
    expect_rd(12'hB00, 32'h0, 1'b1);
    expect_rd(12'hB82, 32'h0, 1'b1);
    expect_rd(12'h320, 32'h0, 1'b1);
    expect_rd(12'h323, 32'h0, 1'b1);
    drain();
    check("irq_reset", 32'(csr_ovf_irq), 32'h0);

    // Ten idle clocks after reset release
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (10) tick();
    force_stall_reset = 1'b1;
    expect_rd(12'hB00, 32'd10, 1'b1);
    expect_rd(12'hB80, 32'd0, 1'b1);
    expect_rd(12'hB02, 32'd10, 1'b1);
    expect_rd(12'hC01, 32'd10, 1'b1);
    expect_rd(12'hC02, 32'd10, 1'b1);
    expect_rd(12'h123, 32'd0, 1'b0);
    expect_rd(12'hB01, 32'd0, 1'b0);
    drain();

    // Ten clocks, execute stalled on five of them
    for (int i = 0; i < 10; i++) begin
      force_stall_reset = 1'b0;
      stall_exe = (i % 2 == 1);
      tick();
    end
    force_stall_reset = 1'b1;
    stall_exe = 1'b0;
    expect_rd(12'hB00, 32'd20, 1'b1);
    expect_rd(12'hB02, 32'd15, 1'b1);
    drain();
    repeat (4) tick();
    expect_rd(12'hB00, 32'd20, 1'b1);
    expect_rd(12'hC02, 32'd15, 1'b1);
    drain();

    // Event counting with cycle/instret inhibited
    csr_wr(12'h320, 32'h5);
    csr_wr(12'h323, 32'd2);
    expect_rd(12'h320, 32'h5, 1'b1);
    expect_rd(12'h323, 32'd2, 1'b1);
    drain();
    force_stall_reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      hpm_events = ev_pat[i];
      tick();
    end
    hpm_events = '0;
    force_stall_reset = 1'b1;
    expect_rd(12'hB03, 32'd3, 1'b1);
    expect_rd(12'hC03, 32'd3, 1'b1);
    expect_rd(12'hB00, 32'd20, 1'b1);
    expect_rd(12'hB02, 32'd15, 1'b1);
    expect_rd(12'hB04, 32'd0, 1'b1);
    drain();

    // Out-of-range and boundary event ids
    csr_wr(12'h323, 32'd31);
    csr_wr(12'h324, 32'd8);
    csr_wr(12'h325, 32'd9);
    force_stall_reset = 1'b0;
    hpm_events = 8'hFF;
    repeat (3) tick();
    hpm_events = '0;
    force_stall_reset = 1'b1;
    expect_rd(12'hB03, 32'd3, 1'b1);
    expect_rd(12'hB04, 32'd3, 1'b1);
    expect_rd(12'hB05, 32'd0, 1'b1);
    expect_rd(12'h325, 32'd9, 1'b1);
    expect_rd(12'h322, 32'd0, 1'b0);
    expect_rd(12'hB07, 32'd0, 1'b0);
    drain();

    // mcountinhibit writable bits
    csr_wr(12'h320, 32'h2);
    expect_rd(12'h320, 32'h0, 1'b1);
    drain();
    csr_wr(12'h320, 32'hFFFF_FFFF);
    expect_rd(12'h320, 32'h7D, 1'b1);
    drain();
    csr_wr(12'h320, 32'h0);

    // Low/high writes while counting, then carry into the high half
    force_stall_reset = 1'b0;
    csr_wr(12'hB00, 32'hFFFF_FFFF);
    csr_wr(12'hB80, 32'h0);
    tick();
    force_stall_reset = 1'b1;
    expect_rd(12'hB00, 32'h0, 1'b1);
    expect_rd(12'hB80, 32'h1, 1'b1);
    expect_rd(12'hC81, 32'h1, 1'b1);
    expect_rd(12'hB02, 32'd18, 1'b1);
    drain();

    // Low write colliding with an increment that would carry
    csr_wr(12'hB00, 32'hFFFF_FFFF);
    force_stall_reset = 1'b0;
    csr_wr(12'hB00, 32'h0000_ABCD);
    force_stall_reset = 1'b1;
    expect_rd(12'hB00, 32'h0000_ABCD, 1'b1);
    expect_rd(12'hB80, 32'h1, 1'b1);
    drain();

`ifdef NANORV32_CSR_OVF_IRQ_EN
    csr_wr(12'h7C1, 32'h8);
    csr_wr(12'h323, 32'd1);
    csr_wr(12'hB03, 32'hFFFF_FFFF);
    csr_wr(12'hB83, 32'hFFFF_FFFF);
    expect_rd(12'h7C1, 32'h8, 1'b1);
    expect_rd(12'h7C0, 32'h0, 1'b1);
    expect_rd(12'hB83, 32'hFFFF_FFFF, 1'b1);
    drain();
    check("irq_pre", 32'(csr_ovf_irq), 32'h0);
    force_stall_reset = 1'b0;
    hpm_events = 8'h01;
    tick();
    hpm_events = '0;
    force_stall_reset = 1'b1;
    check("irq_set", 32'(csr_ovf_irq), 32'h1);
    expect_rd(12'hB03, 32'h0, 1'b1);
    expect_rd(12'hB83, 32'h0, 1'b1);
    expect_rd(12'h7C0, 32'h8, 1'b1);
    drain();
    csr_wr(12'h7C0, 32'h8);
    check("irq_clr", 32'(csr_ovf_irq), 32'h0);
    expect_rd(12'h7C0, 32'h0, 1'b1);
    drain();
`else
    expect_rd(12'h7C0, 32'h0, 1'b0);
    expect_rd(12'h7C1, 32'h0, 1'b0);
    drain();
    check("irq_off", 32'(csr_ovf_irq), 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
